// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand side (in_*), result side (out_*)
// and a status flag. The master is the producer/consumer, the slave is the adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full_adder cell processes one bit pair per
// clock, with the carry kept in a flop between bits. Operands are accepted in
// IDLE, shifted for exactly WIDTH cycles, and the result is held in DONE until
// the consumer takes it.

// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sumf,
    output logic carryf
);
    assign sumf   = a ^ b ^ c;
    assign carryf = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_sumf;
    logic               w_carryf;
    logic               w_last;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;
    logic [WIDTH-1:0]   w_sum_next;

    full_adder u_fa (
        .a      (r_a_sh[0]),
        .b      (r_b_sh[0]),
        .c      (r_carry),
        .sumf   (w_sumf),
        .carryf (w_carryf)
    );

    assign w_last = (r_cnt == LAST_BIT);

    // Partial sum after inserting the current bit at the MSB (works for WIDTH = 1 too).
    always_comb begin
        w_sum_next            = r_sum_sh >> 1;
        w_sum_next[WIDTH-1]   = w_sumf;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode.
    // NOTE: default assignment first so no path leaves w_state_next unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = SHIFT;
            SHIFT:   if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from state only (no input-to-output paths).
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = 1'b1;
            SHIFT:   w_busy      = 1'b1;
            DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: w_in_ready  = 1'b1;
        endcase
    end

    // Datapath: operand load, per-bit shift, and result capture on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_carryf;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum  <= w_sum_next;
                        r_cout <= w_carryf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: three instances (WIDTH 8, 4, 1), each with a
// result scoreboard fed at operand acceptance and drained on output handshakes.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(4)) if4 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [1:0] q1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitors: compare on every result handshake.
    always @(negedge clk) begin
        logic [8:0] e8;
        if (rst_n && if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) check("sb8_unexpected", {23'b0, if8.cout, if8.sum}, 32'hDEAD_BEEF);
            else begin
                e8 = q8.pop_front();
                check("sb8", {23'b0, if8.cout, if8.sum}, {23'b0, e8});
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e4;
        if (rst_n && if4.out_valid && if4.out_ready) begin
            if (q4.size() == 0) check("sb4_unexpected", {27'b0, if4.cout, if4.sum}, 32'hDEAD_BEEF);
            else begin
                e4 = q4.pop_front();
                check("sb4", {27'b0, if4.cout, if4.sum}, {27'b0, e4});
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] e1;
        if (rst_n && if1.out_valid && if1.out_ready) begin
            if (q1.size() == 0) check("sb1_unexpected", {30'b0, if1.cout, if1.sum}, 32'hDEAD_BEEF);
            else begin
                e1 = q1.pop_front();
                check("sb1", {30'b0, if1.cout, if1.sum}, {30'b0, e1});
            end
        end
    end

    // Offer operands to the WIDTH=8 instance; returns the acceptance edge cycle.
    // Operands are scrambled right after acceptance to show they are not re-sampled.
    task automatic put8(input logic [7:0] a, input logic [7:0] b, input logic c, output int t);
        @(posedge clk); #1;
        if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clk);
            if (if8.in_ready) t = cyc + 1;
        end
        if (t < 0) check("put8_timeout", 32'd0, 32'd1);
        else q8.push_back(9'(a) + 9'(b) + 9'(c));
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        if8.a = ~a; if8.b = 8'($urandom); if8.cin = ~c;
    endtask

    task automatic drain8(input string tag);
        int i;
        for (i = 0; i < 60 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) check(tag, q8.size(), 32'd0);
    endtask

    task automatic drain4(input string tag);
        int i;
        for (i = 0; i < 60 && q4.size() != 0; i++) @(negedge clk);
        if (q4.size() != 0) check(tag, q4.size(), 32'd0);
    endtask

    task automatic drain1(input string tag);
        int i;
        for (i = 0; i < 60 && q1.size() != 0; i++) @(negedge clk);
        if (q1.size() != 0) check(tag, q1.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int last;
        int i;
        {if8.in_valid, if8.a, if8.b, if8.cin, if8.out_ready} = '0;
        {if4.in_valid, if4.a, if4.b, if4.cin, if4.out_ready} = '0;
        {if1.in_valid, if1.a, if1.b, if1.cin, if1.out_ready} = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_sum",       {24'b0, if8.sum}, 32'h0);
        check("rst_cout",      {31'b0, if8.cout}, 32'h0);
        check("rst_out_valid", {31'b0, if8.out_valid}, 32'h0);
        check("rst_in_ready",  {31'b0, if8.in_ready}, 32'h1);
        check("rst_busy",      {31'b0, if8.busy}, 32'h0);
        rst_n = 1'b1;

        // Test 1: 0x5A + 0x3C, with per-cycle handshake timing.
        if8.out_ready = 1'b1;
        put8(8'h5A, 8'h3C, 1'b0, t);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("t1_in_ready_k%0d", k), {31'b0, if8.in_ready}, (k == 9) ? 32'd1 : 32'd0);
            check($sformatf("t1_out_valid_k%0d", k), {31'b0, if8.out_valid}, (k == 8) ? 32'd1 : 32'd0);
            if (k == 0) check("t1_busy", {31'b0, if8.busy}, 32'd1);
            if (k == 8) begin
                check("t1_sum",  {24'b0, if8.sum}, 32'h96);
                check("t1_cout", {31'b0, if8.cout}, 32'h0);
            end
        end
        drain8("t1_drain");

        // Test 2: overflow cases.
        put8(8'hFF, 8'h01, 1'b0, t);
        drain8("t2a_drain");
        put8(8'hFF, 8'hFF, 1'b1, t);
        drain8("t2b_drain");

        // Test 3: backpressure in DONE with ignored in_valid pulses.
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
        put8(8'h10, 8'h20, 1'b0, t);
        for (i = 0; i < 40 && !if8.out_valid; i++) @(negedge clk);
        check("t3_valid_seen", {31'b0, if8.out_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_hold_valid_%0d", k), {31'b0, if8.out_valid}, 32'd1);
            check($sformatf("t3_hold_sum_%0d", k),   {24'b0, if8.sum}, 32'h30);
            check($sformatf("t3_hold_cout_%0d", k),  {31'b0, if8.cout}, 32'h0);
            check($sformatf("t3_in_ready_%0d", k),   {31'b0, if8.in_ready}, 32'h0);
            @(posedge clk); #1;
            if8.in_valid = 1'b1;
            if8.a = 8'(k * 37 + 3); if8.b = 8'(k * 11 + 5); if8.cin = k[0];
            @(negedge clk);
        end
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_after_valid",    {31'b0, if8.out_valid}, 32'd0);
        check("t3_after_in_ready", {31'b0, if8.in_ready}, 32'd1);

        // Test 4: reset in the 4th SHIFT cycle; nothing from that operation may appear.
        put8(8'h77, 8'h11, 1'b1, t);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        #1;
        check("t4_in_ready",  {31'b0, if8.in_ready}, 32'd1);
        check("t4_busy",      {31'b0, if8.busy}, 32'd0);
        check("t4_out_valid", {31'b0, if8.out_valid}, 32'd0);
        check("t4_sum",       {24'b0, if8.sum}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("t4_no_pulse_%0d", k), {31'b0, if8.out_valid}, 32'd0);
        end
        put8(8'h01, 8'h02, 1'b0, t);
        drain8("t4_drain");

        // Test 5: exhaustive WIDTH=4 sweep, back-to-back, accept spacing checked.
        if4.out_ready = 1'b1;
        last = -1;
        @(posedge clk);
        for (int c = 0; c < 512; c++) begin
            #1;
            if4.a = c[3:0]; if4.b = c[7:4]; if4.cin = c[8]; if4.in_valid = 1'b1;
            t = -1;
            for (int j = 0; j < 20 && t < 0; j++) begin
                @(negedge clk);
                if (if4.in_ready) t = cyc + 1;
            end
            if (t < 0) check("t5_accept_timeout", 32'd0, 32'd1);
            else begin
                q4.push_back(5'(c[3:0]) + 5'(c[7:4]) + 5'(c[8]));
                if (last >= 0) check("t5_ii", t - last, 32'd6);
                last = t;
            end
            @(posedge clk);
        end
        #1;
        if4.in_valid = 1'b0;
        drain4("t5_drain");

        // Test 6: WIDTH=1, 1+1+1 with latency, then all eight combinations.
        if1.out_ready = 1'b1;
        @(posedge clk); #1;
        if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.in_valid = 1'b1;
        t = -1;
        for (int j = 0; j < 20 && t < 0; j++) begin
            @(negedge clk);
            if (if1.in_ready) t = cyc + 1;
        end
        if (t < 0) check("t6_accept_timeout", 32'd0, 32'd1);
        else q1.push_back(2'b11);
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        @(negedge clk);
        check("t6_valid_T",   {31'b0, if1.out_valid}, 32'd0);
        @(negedge clk);
        check("t6_valid_T1",  {31'b0, if1.out_valid}, 32'd1);
        check("t6_sum",       {31'b0, if1.sum}, 32'd1);
        check("t6_cout",      {31'b0, if1.cout}, 32'd1);
        drain1("t6_drain");
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if1.a = c[0]; if1.b = c[1]; if1.cin = c[2]; if1.in_valid = 1'b1;
            t = -1;
            for (int j = 0; j < 20 && t < 0; j++) begin
                @(negedge clk);
                if (if1.in_ready) t = cyc + 1;
            end
            if (t < 0) check("t6_sweep_timeout", 32'd0, 32'd1);
            else q1.push_back(2'(c[0]) + 2'(c[1]) + 2'(c[2]));
            @(posedge clk); #1;
            if1.in_valid = 1'b0;
        end
        drain1("t6_sweep_drain");

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
